// File: rtl/calculator_core_if.sv
// Operand/result bus of the calculator core.
// master drives switches and pulses; slave returns A, B, C and status.
interface calculator_core_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] sw;
   logic             ld;
   logic             exec;
   logic             clr;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] C;
   logic             flag;
   logic             busy;
   logic             done;

   modport master (
      output sw, ld, exec, clr, op,
      input  A, B, C, flag, busy, done
   );

   modport slave (
      input  sw, ld, exec, clr, op,
      output A, B, C, flag, busy, done
   );
endinterface

// File: rtl/calculator_core.sv
// Operand entry plus ADD/SUB and iterative MUL/DIV for the calculator.
// Define CALC_DIV_EN to build the restoring divider for op=11.
module calculator_core #(
   parameter int WIDTH    = 16,
   parameter int ITER_CNT = 16
) (
   input logic               clk,
   input logic               rst,
   calculator_core_if.slave  bus
);

   typedef enum logic [2:0] {
      S_A,
      S_B,
      S_OP,
      S_BUSY,
      S_DONE
   } state_t;

   localparam int CW = $clog2(ITER_CNT + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
`ifdef CALC_DIV_EN
   logic             is_div;
   logic [WIDTH:0]   shifted;
   logic             fits;
`endif

   // hi:lo is the shared product / remainder:quotient register pair
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bus.A} : '0);
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef CALC_DIV_EN
      shifted = {hi, lo[WIDTH-1]};
      fits    = shifted >= {1'b0, bus.B};
      if (is_div) begin
         step_hi = fits ? WIDTH'(shifted - {1'b0, bus.B})
                        : shifted[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], fits};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_A;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         bus.A    <= '0;
         bus.B    <= '0;
         bus.C    <= '0;
         bus.flag <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
`ifdef CALC_DIV_EN
         is_div   <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         if (bus.clr) begin
            state    <= S_A;
            bus.A    <= '0;
            bus.B    <= '0;
            bus.C    <= '0;
            bus.flag <= 1'b0;
            bus.busy <= 1'b0;
         end else begin
            unique case (state)
               S_A: if (bus.ld) begin
                  bus.A <= bus.sw;
                  state <= S_B;
               end
               S_B: if (bus.ld) begin
                  bus.B <= bus.sw;
                  state <= S_OP;
               end
               S_OP: if (bus.exec) begin
                  unique case (bus.op)
                     2'b00: begin
                        {bus.flag, bus.C} <= {1'b0, bus.A} + {1'b0, bus.B};
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                     end
                     2'b01: begin
                        bus.C    <= bus.A - bus.B;
                        bus.flag <= bus.A < bus.B;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                     end
                     2'b10: begin
                        hi       <= '0;
                        lo       <= bus.B;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_BUSY;
`ifdef CALC_DIV_EN
                        is_div   <= 1'b0;
`endif
                     end
                     default: begin
`ifdef CALC_DIV_EN
                        if (bus.B == '0) begin
                           bus.C    <= '1;
                           bus.flag <= 1'b1;
                           bus.done <= 1'b1;
                           state    <= S_DONE;
                        end else begin
                           hi       <= '0;
                           lo       <= bus.A;
                           cnt      <= '0;
                           is_div   <= 1'b1;
                           bus.busy <= 1'b1;
                           state    <= S_BUSY;
                        end
`else
                        bus.C    <= '0;
                        bus.flag <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
`endif
                     end
                  endcase
               end
               S_BUSY: begin
                  hi  <= step_hi;
                  lo  <= step_lo;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(ITER_CNT - 1)) begin
                     bus.C    <= step_lo;
`ifdef CALC_DIV_EN
                     bus.flag <= !is_div && (|step_hi);
`else
                     bus.flag <= |step_hi;
`endif
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                     state    <= S_DONE;
                  end
               end
               S_DONE: if (bus.ld) begin
                  bus.A    <= bus.sw;
                  bus.B    <= '0;
                  bus.C    <= '0;
                  bus.flag <= 1'b0;
                  state    <= S_B;
               end
               default: state <= S_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calculator_core.sv
// Directed bench for calculator_core: entry, ALU ops, latency, clr, reset.
// Expected values are hand-computed constants.
module tb_calculator_core;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   lat;
   int   nbusy;
   logic saw_done;

   calculator_core_if #(.WIDTH(16)) bus ();

   calculator_core #(
      .WIDTH    (16),
      .ITER_CNT (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [15:0] v);
      @(negedge clk);
      bus.sw = v;
      bus.ld = 1'b1;
      @(negedge clk);
      bus.ld = 1'b0;
   endtask

   // pulse exec, then count cycles (and busy cycles) until done
   task automatic run_op(input logic [1:0] o);
      @(negedge clk);
      bus.op   = o;
      bus.exec = 1'b1;
      @(negedge clk);
      bus.exec = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".A"}, 32'(bus.A), 32'h0);
      check({tag, ".B"}, 32'(bus.B), 32'h0);
      check({tag, ".C"}, 32'(bus.C), 32'h0);
      check({tag, ".flag"}, 32'(bus.flag), 32'h0);
      check({tag, ".busy"}, 32'(bus.busy), 32'h0);
      check({tag, ".done"}, 32'(bus.done), 32'h0);
   endtask

   initial begin
      bus.sw   = '0;
      bus.ld   = 1'b0;
      bus.exec = 1'b0;
      bus.clr  = 1'b0;
      bus.op   = 2'b00;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      // exec in S_A is ignored
      @(negedge clk);
      bus.exec = 1'b1;
      @(negedge clk);
      bus.exec = 1'b0;
      check("exec_in_S_A", 32'(bus.done), 32'h0);

      // ADD 5 + 3
      load(16'h0005);
      load(16'h0003);
      check("add1.A", 32'(bus.A), 32'h5);
      check("add1.B", 32'(bus.B), 32'h3);
      load(16'h1234);
      check("ld_in_S_OP.A", 32'(bus.A), 32'h5);
      check("ld_in_S_OP.B", 32'(bus.B), 32'h3);
      run_op(2'b00);
      check("add1.lat", 32'(lat), 32'd1);
      check("add1.C", 32'(bus.C), 32'h0008);
      check("add1.flag", 32'(bus.flag), 32'h0);
      @(negedge clk);
      check("add1.done_pulse", 32'(bus.done), 32'h0);

      // ld in S_DONE restarts with B, C, flag cleared
      load(16'hFFFF);
      check("redo.A", 32'(bus.A), 32'hFFFF);
      check("redo.B", 32'(bus.B), 32'h0);
      check("redo.C", 32'(bus.C), 32'h0);
      load(16'h0001);
      run_op(2'b00);
      check("add2.C", 32'(bus.C), 32'h0000);
      check("add2.flag", 32'(bus.flag), 32'h1);

      // SUB 3 - 5
      load(16'h0003);
      check("sub.flag_clr", 32'(bus.flag), 32'h0);
      load(16'h0005);
      run_op(2'b01);
      check("sub.lat", 32'(lat), 32'd1);
      check("sub.C", 32'(bus.C), 32'hFFFE);
      check("sub.flag", 32'(bus.flag), 32'h1);

      // MUL overflow
      load(16'h0100);
      load(16'h0100);
      run_op(2'b10);
      check("mul1.lat", 32'(lat), 32'd17);
      check("mul1.busy_cycles", 32'(nbusy), 32'd16);
      check("mul1.busy_end", 32'(bus.busy), 32'h0);
      check("mul1.C", 32'(bus.C), 32'h0000);
      check("mul1.flag", 32'(bus.flag), 32'h1);
      @(negedge clk);
      check("mul1.done_pulse", 32'(bus.done), 32'h0);

      // MUL in range
      load(16'h1234);
      load(16'h0005);
      run_op(2'b10);
      check("mul2.C", 32'(bus.C), 32'h5B04);
      check("mul2.flag", 32'(bus.flag), 32'h0);

      // MUL max
      load(16'hFFFF);
      load(16'hFFFF);
      run_op(2'b10);
      check("mul3.C", 32'(bus.C), 32'h0001);
      check("mul3.flag", 32'(bus.flag), 32'h1);

`ifdef CALC_DIV_EN
      load(16'h0064);
      load(16'h0007);
      run_op(2'b11);
      check("div.lat", 32'(lat), 32'd17);
      check("div.C", 32'(bus.C), 32'h000E);
      check("div.flag", 32'(bus.flag), 32'h0);
      load(16'hFFFF);
      load(16'h0010);
      run_op(2'b11);
      check("div2.C", 32'(bus.C), 32'h0FFF);
      check("div2.flag", 32'(bus.flag), 32'h0);
      load(16'h0064);
      load(16'h0000);
      run_op(2'b11);
      check("div0.lat", 32'(lat), 32'd1);
      check("div0.C", 32'(bus.C), 32'hFFFF);
      check("div0.flag", 32'(bus.flag), 32'h1);
`else
      load(16'h0064);
      load(16'h0007);
      run_op(2'b11);
      check("nodiv.lat", 32'(lat), 32'd1);
      check("nodiv.busy_cycles", 32'(nbusy), 32'd0);
      check("nodiv.C", 32'(bus.C), 32'h0000);
      check("nodiv.flag", 32'(bus.flag), 32'h1);
`endif

      // clr on cycle 5 of MUL
      load(16'h0100);
      load(16'h0100);
      @(negedge clk);
      bus.op   = 2'b10;
      bus.exec = 1'b1;
      @(negedge clk);
      bus.exec = 1'b0;
      check("clr.busy_start", 32'(bus.busy), 32'h1);
      repeat (3) @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr  = 1'b0;
      saw_done = 1'b0;
      repeat (25) begin
         if (bus.done) saw_done = 1'b1;
         @(negedge clk);
      end
      check("clr.no_done", 32'(saw_done), 32'h0);
      check_zero("clr");
      load(16'h0007);
      check("clr.S_A.A", 32'(bus.A), 32'h7);
      check("clr.S_A.B", 32'(bus.B), 32'h0);

      // async reset mid-MUL
      load(16'h0100);
      run_op(2'b00);
      load(16'h0100);
      load(16'h0100);
      @(negedge clk);
      bus.op   = 2'b10;
      bus.exec = 1'b1;
      @(negedge clk);
      bus.exec = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1 check_zero("rst_async");
      @(negedge clk);
      rst      = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin
         if (bus.done) saw_done = 1'b1;
         @(negedge clk);
      end
      check("rst.no_done", 32'(saw_done), 32'h0);
      load(16'h0009);
      check("rst.S_A.A", 32'(bus.A), 32'h9);
      check("rst.S_A.B", 32'(bus.B), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
